tnaf_digit_stack: RTL and testbench
===================================

# tnaf_digit_stack

Buffers the tau-NAF digit stream produced LSB-first by the accumulator during tau-NAF generation, packing it into 16-bit words, 8 digits per word. It replays the digits MSB-first, with a valid/ready handshake, to the point-multiplication sequencer, which performs Frobenius and add/sub per digit. It also latches the final-adjustment flag and presents it after the last digit.

## Interface
- MAX_DIGITS, 288: maximum digits stored; word depth is ceil(MAX_DIGITS/8).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- start_load  in  1  clears the stack and enters LOAD; accepted in any state.
- din_valid  in  1  din holds a digit this cycle.
- din  in  2  digit encoding: 00=0, 01=+1, 11=-1, 10=invalid.
- load_done  in  1  end of generation.
- flag_adj_in  in  2  adjustment flag from the accumulator; sampled with load_done.
- dout_ready  in  1  sequencer accepts dout.
- dout_valid  out  1  dout holds a digit.
- dout  out  2  digit, same encoding as din.
- dout_last  out  1  dout is the least significant digit.
- done  out  1  one-cycle pulse on entry to DONE.
- adj_req  out  1  add/sub adjustment needed; equals flag[1]; held in DONE.
- adj_sub  out  1  1 = subtract (tau+1)P, 0 = add (tau-1)P; equals flag[0]; valid when adj_req=1.
- busy  out  1  state is LOAD or DRAIN.
- digit_count  out  10  effective length, without leading zeros.
- err_invalid  out  1  sticky; an invalid encoding was received.
- overflow  out  1  sticky; a digit arrived after MAX_DIGITS were stored.

## Operation
- States: IDLE, LOAD, DRAIN, DONE. Reset goes to IDLE.
- IDLE -> LOAD on start_load.
- In LOAD, each din_valid cycle stores din at index wr_idx, then wr_idx increments.
  - Storage location: word wr_idx[9:3], bits [2k+1:2k] with k = wr_idx[2:0].
  - The current word is assembled in a pack register and written to the array on the 8th digit, or on load_done if the word is partial.
- Invalid digit 10: stored as 00, and err_invalid is set.
- Full stack: when wr_idx == MAX_DIGITS, the digit is dropped, overflow is set, and wr_idx holds.
- msnz tracking: msnz = highest index written with a nonzero digit. Effective length len = msnz+1, or 0 if no nonzero digit was stored. digit_count = len.
- LOAD on load_done:
  - If din_valid is also high, the digit is accepted first.
  - flag is latched from flag_adj_in.
  - Next state is DRAIN if len > 0, otherwise DONE.
- In DRAIN, rd_idx starts at len-1 and the stack is presented MSB-first.
  - On dout_valid & dout_ready, rd_idx decrements.
  - dout_last = (rd_idx == 0).
  - The transfer of the last digit moves the state to DONE.
- In DONE: done pulses once; adj_req and adj_sub drive from flag until start_load or rst.
- start_load in LOAD, DRAIN or DONE aborts the current operation. It clears wr_idx, msnz, the pack register, flag, err_invalid and overflow, then enters LOAD. Array contents are not cleared; they are overwritten.
- The array is register-based with no reset. Stale contents never appear on dout because only indices below len are read.

## Timing
- Reset values: every output 0, state IDLE.
- LOAD throughput: 1 digit per cycle; no backpressure on din.
- load_done at edge t: the state is DRAIN at t+1.
  - dout_valid rises at t+2 with the MSB digit; the prefetch is registered.
- DRAIN throughput: 1 digit per cycle while dout_ready is held high.
- dout is registered. dout and dout_valid are stable while dout_ready=0.
- A dout_ready=1 cycle with dout_valid=0 has no effect.
- Final transfer at edge t: dout_valid=0 and done=1 at t+1; adj outputs valid from t+1.
- len=0: done=1 the cycle after load_done; dout_valid never rises.
- rst mid-LOAD or mid-DRAIN: IDLE on the next edge; all outputs 0, including the sticky flags.

## Test plan
- Load 01,00,11,01 (LSB-first) with flag 11, then drain with ready held high -> dout 01,11,00,01; dout_last on the 4th; digit_count=4; done; adj_req=1, adj_sub=1.
- Load 10 digits ending in two 00s -> digit_count=8; 8 digits out, MSB-first. Confirms word-boundary flush with leading-zero trim.
- Load 288 random digits plus 1 extra -> overflow=1; the replay equals the first 288 digits reversed, trimmed of leading zeros.
- Drain with random dout_ready (about 30% low) -> no digit lost or duplicated; dout stable while stalled.
- Load all-zero digits with flag 10 -> no dout_valid; done the cycle after load_done; adj_req=1, adj_sub=0.
- Send din=10 -> err_invalid=1 and the digit replays as 00. Assert start_load mid-DRAIN -> LOAD and err_invalid=0 on the next cycle. Assert rst mid-DRAIN -> all outputs 0.

Source files
------------

// File: rtl/tnaf_digit_stack_if.sv
// Handshake and status bundle between the tau-NAF accumulator, the digit stack and the sequencer.
interface tnaf_digit_stack_if;
    logic       start_load;
    logic       din_valid;
    logic [1:0] din;
    logic       load_done;
    logic [1:0] flag_adj_in;
    logic       dout_ready;
    logic       dout_valid;
    logic [1:0] dout;
    logic       dout_last;
    logic       done;
    logic       adj_req;
    logic       adj_sub;
    logic       busy;
    logic [9:0] digit_count;
    logic       err_invalid;
    logic       overflow;

    modport master (
        output start_load, din_valid, din, load_done, flag_adj_in, dout_ready,
        input  dout_valid, dout, dout_last, done, adj_req, adj_sub, busy,
               digit_count, err_invalid, overflow
    );

    modport slave (
        input  start_load, din_valid, din, load_done, flag_adj_in, dout_ready,
        output dout_valid, dout, dout_last, done, adj_req, adj_sub, busy,
               digit_count, err_invalid, overflow
    );
endinterface

// File: rtl/tnaf_digit_stack.sv
// Packs an LSB-first tau-NAF digit stream into 16-bit words and replays it MSB-first,
// trimmed of leading zeros, then presents the final-adjustment flag.
//
// state   | meaning
// S_IDLE  | after reset, waiting for start_load
// S_LOAD  | accepting digits from the accumulator
// S_DRAIN | replaying digits MSB-first to the sequencer
// S_DONE  | replay finished, adjustment flag presented
module tnaf_digit_stack #(
    parameter int MAX_DIGITS = 288
) (
    input logic               clk,
    input logic               rst,
    tnaf_digit_stack_if.slave bus
);
    localparam int DEPTH = (MAX_DIGITS + 7) / 8;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IW    = AW + 3;
    localparam logic [9:0] MAX_IDX = 10'(MAX_DIGITS);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;
    state_t state, state_nx;

    logic [15:0]   mem [DEPTH];
    logic [15:0]   pack, pack_after, rd_word;
    logic [9:0]    wr_idx, msnz, rd_idx, len_cur, len_after;
    logic [IW-1:0] wr_after, rd_sel;
    logic [AW-1:0] mem_waddr;
    logic [1:0]    flag, din_clean, rd_digit, dout_q;
    logic          have_nz, stack_full, accept, nz_accept, mem_we;
    logic          dout_valid_q, dout_last_q, done_q, err_q, ovf_q;

    always_comb begin
        stack_full = (wr_idx == MAX_IDX);
        din_clean  = (bus.din == 2'b10) ? 2'b00 : bus.din;
        accept     = (state == S_LOAD) && !bus.start_load && bus.din_valid && !stack_full;
        nz_accept  = accept && (din_clean != 2'b00);
        len_cur    = have_nz ? msnz + 10'd1 : 10'd0;
        len_after  = nz_accept ? wr_idx + 10'd1 : len_cur;
        wr_after   = accept ? IW'(wr_idx + 10'd1) : IW'(wr_idx);
        pack_after = pack;
        if (accept)
            pack_after[{wr_idx[2:0], 1'b0} +: 2] = din_clean;
        // a full word goes out on its 8th digit; a partial one only when loading ends
        mem_we    = 1'b0;
        mem_waddr = wr_idx[AW+2:3];
        if (accept && wr_idx[2:0] == 3'd7) begin
            mem_we = 1'b1;
        end else if (state == S_LOAD && !bus.start_load && bus.load_done && wr_after[2:0] != 3'd0) begin
            mem_we    = 1'b1;
            mem_waddr = wr_after[AW+2:3];
        end
    end

    always_comb begin
        rd_sel   = (dout_valid_q && rd_idx != 10'd0) ? IW'(rd_idx - 10'd1) : IW'(rd_idx);
        rd_word  = mem[rd_sel[AW+2:3]];
        rd_digit = rd_word[{rd_sel[2:0], 1'b0} +: 2];
    end

    always_comb begin
        state_nx = state;
        if (bus.start_load) begin
            state_nx = S_LOAD;
        end else begin
            case (state)
                S_LOAD:  if (bus.load_done) state_nx = (len_after != 10'd0) ? S_DRAIN : S_DONE;
                S_DRAIN: if (dout_valid_q && bus.dout_ready && dout_last_q) state_nx = S_DONE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= pack_after;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx       <= '0;
            msnz         <= '0;
            have_nz      <= 1'b0;
            pack         <= '0;
            flag         <= '0;
            err_q        <= 1'b0;
            ovf_q        <= 1'b0;
            rd_idx       <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= (state_nx == S_DONE) && (state != S_DONE);
            if (bus.start_load) begin
                wr_idx       <= '0;
                msnz         <= '0;
                have_nz      <= 1'b0;
                pack         <= '0;
                flag         <= '0;
                err_q        <= 1'b0;
                ovf_q        <= 1'b0;
                rd_idx       <= '0;
                dout_q       <= '0;
                dout_valid_q <= 1'b0;
                dout_last_q  <= 1'b0;
            end else if (state == S_LOAD) begin
                if (bus.din_valid && bus.din == 2'b10) err_q <= 1'b1;
                if (bus.din_valid && stack_full)       ovf_q <= 1'b1;
                if (accept) begin
                    wr_idx <= wr_idx + 10'd1;
                    pack   <= (wr_idx[2:0] == 3'd7) ? 16'd0 : pack_after;
                    if (nz_accept) begin
                        msnz    <= wr_idx;
                        have_nz <= 1'b1;
                    end
                end
                if (bus.load_done) begin
                    flag   <= bus.flag_adj_in;
                    rd_idx <= len_after - 10'd1;
                end
            end else if (state == S_DRAIN) begin
                // empty output register: prefetch the digit at rd_idx
                if (!dout_valid_q) begin
                    dout_q       <= rd_digit;
                    dout_valid_q <= 1'b1;
                    dout_last_q  <= (rd_idx == 10'd0);
                end else if (bus.dout_ready) begin
                    if (dout_last_q) begin
                        dout_q       <= '0;
                        dout_valid_q <= 1'b0;
                        dout_last_q  <= 1'b0;
                    end else begin
                        rd_idx      <= rd_idx - 10'd1;
                        dout_q      <= rd_digit;
                        dout_last_q <= (rd_idx == 10'd1);
                    end
                end
            end
        end
    end

    assign bus.dout_valid  = dout_valid_q;
    assign bus.dout        = dout_q;
    assign bus.dout_last   = dout_last_q;
    assign bus.done        = done_q;
    assign bus.adj_req     = (state == S_DONE) && flag[1];
    assign bus.adj_sub     = (state == S_DONE) && flag[0];
    assign bus.busy        = (state == S_LOAD) || (state == S_DRAIN);
    assign bus.digit_count = len_cur;
    assign bus.err_invalid = err_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_tnaf_digit_stack.sv
// Randomized bench for tnaf_digit_stack: a queue model derives the expected MSB-first replay.
module tb_tnaf_digit_stack;
    localparam int MAXD = 288;

    logic clk = 1'b0;
    logic rst;
    tnaf_digit_stack_if bus();

    tnaf_digit_stack #(.MAX_DIGITS(MAXD)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];
    int got_q[$];
    int stim[$];
    int m_len;
    bit m_err, m_ovf;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rnd_digit(input int inv_pct);
        int sel;
        if (int'($urandom_range(99)) < inv_pct) return 2;
        sel = $urandom_range(2);
        return (sel == 0) ? 0 : (sel == 1) ? 1 : 3;
    endfunction

    // expected replay: first MAXD digits kept, invalid -> 0, reversed, leading zeros trimmed
    function automatic void model();
        int kept[$];
        m_err = 0;
        m_len = 0;
        m_ovf = (stim.size() > MAXD);
        foreach (stim[i]) begin
            if (stim[i] == 2) m_err = 1;
            if (i < MAXD) kept.push_back((stim[i] == 2) ? 0 : stim[i]);
        end
        foreach (kept[i]) if (kept[i] != 0) m_len = i + 1;
        exp_q.delete();
        for (int i = m_len - 1; i >= 0; i--) exp_q.push_back(kept[i]);
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.done) check("done_early", exp_q.size(), 0);
            if (bus.dout_valid) begin
                if (exp_q.size() == 0) begin
                    check("extra_digit", 1, 0);
                end else begin
                    check("dout", int'(bus.dout), exp_q[0]);
                    check("dout_last", int'(bus.dout_last), int'(exp_q.size() == 1));
                    if (bus.dout_ready) begin
                        got_q.push_back(int'(bus.dout));
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic load(input logic [1:0] flag);
        model();
        got_q.delete();
        bus.start_load = 1'b1;
        tick();
        bus.start_load = 1'b0;
        for (int i = 0; i < stim.size(); i++) begin
            bus.din_valid   = 1'b1;
            bus.din         = 2'(stim[i]);
            bus.load_done   = (i == stim.size() - 1);
            bus.flag_adj_in = flag;
            tick();
        end
        if (stim.size() == 0) begin
            bus.load_done   = 1'b1;
            bus.flag_adj_in = flag;
            tick();
        end
        bus.din_valid = 1'b0;
        bus.load_done = 1'b0;
        bus.din       = 2'b00;
        check("digit_count", int'(bus.digit_count), m_len);
        check("err_invalid", int'(bus.err_invalid), int'(m_err));
        check("overflow", int'(bus.overflow), int'(m_ovf));
        if (m_len == 0) begin
            check("done_len0", int'(bus.done), 1);
            check("busy_len0", int'(bus.busy), 0);
        end else begin
            check("busy_drain", int'(bus.busy), 1);
        end
    endtask

    task automatic drain(input int pct_low, input logic [1:0] flag);
        int cyc = 0;
        bit seen = 0;
        if (m_len > 0) begin
            check("valid_t1", int'(bus.dout_valid), 0);
            bus.dout_ready = (int'($urandom_range(99)) >= pct_low);
            tick();
            check("valid_t2", int'(bus.dout_valid), 1);
            while (!seen && cyc < 4000) begin
                bus.dout_ready = (int'($urandom_range(99)) >= pct_low);
                tick();
                cyc++;
                if (bus.done) seen = 1;
            end
            check("drain_timeout", int'(seen), 1);
        end
        check("drained_all", exp_q.size(), 0);
        check("valid_in_done", int'(bus.dout_valid), 0);
        check("adj_req", int'(bus.adj_req), int'(flag[1]));
        check("adj_sub", int'(bus.adj_sub), int'(flag[0]));
        check("busy_done", int'(bus.busy), 0);
        bus.dout_ready = 1'b0;
        tick();
        check("done_pulse", int'(bus.done), 0);
        check("adj_hold", int'(bus.adj_req), int'(flag[1]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [1:0] f;
        int n;
        bus.start_load  = 1'b0;
        bus.din_valid   = 1'b0;
        bus.din         = 2'b00;
        bus.load_done   = 1'b0;
        bus.flag_adj_in = 2'b00;
        bus.dout_ready  = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_dout_valid", int'(bus.dout_valid), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_count", int'(bus.digit_count), 0);
        check("rst_adj_req", int'(bus.adj_req), 0);
        check("rst_err", int'(bus.err_invalid), 0);

        // basic four-digit replay
        stim = '{1, 0, 3, 1};
        load(2'b11);
        drain(0, 2'b11);
        check("t1_len", got_q.size(), 4);
        if (got_q.size() == 4) begin
            check("t1_d0", got_q[0], 1);
            check("t1_d1", got_q[1], 3);
            check("t1_d2", got_q[2], 0);
            check("t1_d3", got_q[3], 1);
        end
        check("t1_count", int'(bus.digit_count), 4);

        // crosses a word boundary, two leading zeros trimmed
        stim = '{1, 3, 1, 0, 3, 1, 0, 1, 0, 0};
        load(2'b01);
        check("t2_model_len", m_len, 8);
        drain(0, 2'b01);
        check("t2_len", got_q.size(), 8);
        if (got_q.size() == 8) check("t2_msb", got_q[0], 1);

        // full stack plus one extra digit
        stim.delete();
        for (int i = 0; i < MAXD + 1; i++) stim.push_back(rnd_digit(0));
        load(2'b00);
        check("t3_overflow", int'(bus.overflow), 1);
        drain(0, 2'b00);

        // random lengths, some invalid digits, random backpressure
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, MAXD);
            stim.delete();
            for (int i = 0; i < n; i++) stim.push_back(rnd_digit(5));
            f = 2'($urandom_range(3));
            load(f);
            drain(30, f);
        end

        // all-zero load
        stim = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        load(2'b10);
        drain(0, 2'b10);

        // invalid digit, then abort mid-drain with start_load
        stim = '{2, 1, 0, 3};
        load(2'b00);
        check("t6_err", int'(bus.err_invalid), 1);
        bus.dout_ready = 1'b1;
        tick();
        tick();
        bus.dout_ready = 1'b0;
        bus.start_load = 1'b1;
        tick();
        bus.start_load = 1'b0;
        exp_q.delete();
        check("abort_busy", int'(bus.busy), 1);
        check("abort_err", int'(bus.err_invalid), 0);
        check("abort_valid", int'(bus.dout_valid), 0);
        check("abort_count", int'(bus.digit_count), 0);

        // reset mid-drain
        stim = '{1, 3, 3};
        load(2'b11);
        bus.dout_ready = 1'b1;
        tick();
        tick();
        bus.dout_ready = 1'b0;
        rst = 1'b1;
        tick();
        exp_q.delete();
        check("rst_mid_valid", int'(bus.dout_valid), 0);
        check("rst_mid_dout", int'(bus.dout), 0);
        check("rst_mid_busy", int'(bus.busy), 0);
        check("rst_mid_count", int'(bus.digit_count), 0);
        check("rst_mid_done", int'(bus.done), 0);
        check("rst_mid_adj", int'(bus.adj_req), 0);
        rst = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
